// File: rtl/pacman_motion_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pacman_motion_ctrl_pkg
// Shared types, maze geometry and helper functions for the Pacman motion
// controller.
//   dir_t      : facing direction, RIGHT=0 LEFT=1 UP=2 DOWN=3
//   state_t    : STOPPED / MOVING
//   nbr_t      : neighbour tile query result (coords, off-map flag, tunnel flag)
//   opposite() : reverse of a direction
//   neighbour(): tile next to (tx,ty) in a direction, with tunnel wrapping
// ---------------------------------------------------------------------------
package pacman_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } state_t;

  localparam int MAP_W      = 28;
  localparam int MAP_H      = 36;
  localparam int TILE       = 8;
  localparam int TILE_SHIFT = 3;
  localparam int TUNNEL_ROW = 17;
  localparam int START_X    = 80;
  localparam int START_Y    = 64;

  // Leftmost pixel column of the last tile; the tunnel wraps between here and 0.
  localparam logic [8:0] WRAP_X = 9'((MAP_W - 1) * TILE);

  typedef struct packed {
    logic [4:0] tx;
    logic [5:0] ty;
    logic       outside;
    logic       tunnel;
  } nbr_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      RIGHT:   r = LEFT;
      LEFT:    r = RIGHT;
      UP:      r = DOWN;
      default: r = UP;
    endcase
    return r;
  endfunction

  // Neighbour of (tx,ty) in direction d. Stepping sideways off the tunnel row
  // lands on the opposite edge column and is flagged as tunnel (always free);
  // any other step off the map is flagged outside (always a wall).
  function automatic nbr_t neighbour(input logic [4:0] tx, input logic [5:0] ty,
                                     input dir_t d);
    int   nx;
    int   ny;
    nbr_t n;
    nx = int'(tx);
    ny = int'(ty);
    case (d)
      RIGHT:   nx = nx + 1;
      LEFT:    nx = nx - 1;
      UP:      ny = ny - 1;
      default: ny = ny + 1;
    endcase
    n.tx      = nx[4:0];
    n.ty      = ny[5:0];
    n.outside = 1'b0;
    n.tunnel  = 1'b0;
    if (ny < 0 || ny >= MAP_H) begin
      n.outside = 1'b1;
    end else if (nx < 0 || nx >= MAP_W) begin
      if (ny == TUNNEL_ROW) begin
        n.tunnel = 1'b1;
        n.tx     = (nx < 0) ? 5'(MAP_W - 1) : 5'd0;
      end else begin
        n.outside = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_dir_req.sv
// ---------------------------------------------------------------------------
// pacman_dir_req
// Button priority encoder plus "requested direction" latch. The latest press
// is remembered until the motion controller consumes it by turning.
//   CLK60HZ     : frame clock
//   rst         : synchronous active-high reset, drops any pending request
//   i_btnU/D/L/R: raw level buttons, priority U > D > L > R
//   i_consume   : motion controller has adopted the request this edge
//   o_reqDir    : requested direction (dir_t encoding)
//   o_reqValid  : a request is pending
// ---------------------------------------------------------------------------
module pacman_dir_req
  import pacman_motion_ctrl_pkg::*;
(
  input  logic       CLK60HZ,
  input  logic       rst,
  input  logic       i_btnU,
  input  logic       i_btnD,
  input  logic       i_btnL,
  input  logic       i_btnR,
  input  logic       i_consume,
  output logic [1:0] o_reqDir,
  output logic       o_reqValid
);

  dir_t r_reqDir;
  logic r_reqValid;
  dir_t w_pressDir;
  logic w_anyPress;

  assign w_anyPress = i_btnU | i_btnD | i_btnL | i_btnR;

  // Pick the highest-priority button that is down; RIGHT is the fall-through
  // and is only used when w_anyPress says some button is actually held.
  always_comb begin
    w_pressDir = RIGHT;
    if (i_btnU) begin
      w_pressDir = UP;
    end else if (i_btnD) begin
      w_pressDir = DOWN;
    end else if (i_btnL) begin
      w_pressDir = LEFT;
    end
  end

  // A fresh press always wins over consumption, so a held button keeps the
  // request alive even on the edge where the previous one was adopted.
  always_ff @(posedge CLK60HZ) begin
    if (rst) begin
      r_reqValid <= 1'b0;
      r_reqDir   <= LEFT;
    end else if (w_anyPress) begin
      r_reqValid <= 1'b1;
      r_reqDir   <= w_pressDir;
    end else if (i_consume) begin
      r_reqValid <= 1'b0;
    end
  end

  assign o_reqDir   = r_reqDir;
  assign o_reqValid = r_reqValid;

endmodule

// File: rtl/pacman_motion_ctrl.sv
// ---------------------------------------------------------------------------
// pacman_motion_ctrl
// Turns the four buttons into a maze-legal Pacman position, one pixel per
// frame. Perpendicular turns only happen at tile alignment, reversals happen
// at once, walls stop motion, and the tunnel row wraps horizontally.
//   CLK60HZ, rst          : frame clock, synchronous active-high reset
//   BTNU/BTND/BTNL/BTNR   : level buttons
//   q_cur_tx/ty, q_cur_wall : map query for the tile ahead in dir
//   q_req_tx/ty, q_req_wall : map query for the tile ahead in requested dir
//   x_pac, y_pac          : registered top-left pixel position
//   dir                   : current facing direction (dir_t)
//   moving                : 1 while in the MOVING state
// ---------------------------------------------------------------------------
module pacman_motion_ctrl
  import pacman_motion_ctrl_pkg::*;
(
  input  logic       CLK60HZ,
  input  logic       rst,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  output logic [4:0] q_cur_tx,
  output logic [5:0] q_cur_ty,
  input  logic       q_cur_wall,
  output logic [4:0] q_req_tx,
  output logic [5:0] q_req_ty,
  input  logic       q_req_wall,
  output logic [8:0] x_pac,
  output logic [8:0] y_pac,
  output logic [1:0] dir,
  output logic       moving
);

  logic [8:0] r_x;
  logic [8:0] r_y;
  dir_t       r_dir;
  state_t     r_state;

  logic [8:0] w_nextX;
  logic [8:0] w_nextY;
  dir_t       w_nextDir;
  state_t     w_nextState;

  logic [1:0] w_reqDirRaw;
  logic       w_reqValid;
  dir_t       w_reqDir;
  dir_t       w_effReq;
  logic       w_consume;

  logic [4:0] w_tx;
  logic [5:0] w_ty;
  logic       w_aligned;
  nbr_t       w_curNbr;
  nbr_t       w_reqNbr;
  logic       w_curBlocked;
  logic       w_reqBlocked;
  logic       w_turn;
  dir_t       w_moveDir;
  logic       w_moveBlocked;

  pacman_dir_req u_dirReq (
    .CLK60HZ    (CLK60HZ),
    .rst        (rst),
    .i_btnU     (BTNU),
    .i_btnD     (BTND),
    .i_btnL     (BTNL),
    .i_btnR     (BTNR),
    .i_consume  (w_consume),
    .o_reqDir   (w_reqDirRaw),
    .o_reqValid (w_reqValid)
  );

  assign w_reqDir = dir_t'(w_reqDirRaw);
  assign w_effReq = w_reqValid ? w_reqDir : r_dir;

  // x never exceeds 216 and y never exceeds 280, so the tile indices fit in
  // 5 and 6 bits respectively.
  assign w_tx      = r_x[TILE_SHIFT+4:TILE_SHIFT];
  assign w_ty      = r_y[TILE_SHIFT+5:TILE_SHIFT];
  assign w_aligned = (r_x[TILE_SHIFT-1:0] == '0) && (r_y[TILE_SHIFT-1:0] == '0);

  assign w_curNbr = neighbour(w_tx, w_ty, r_dir);
  assign w_reqNbr = neighbour(w_tx, w_ty, w_effReq);

  assign q_cur_tx = w_curNbr.tx;
  assign q_cur_ty = w_curNbr.ty;
  assign q_req_tx = w_reqNbr.tx;
  assign q_req_ty = w_reqNbr.ty;

  // Tunnel exits are open no matter what the ROM says about the wrapped
  // column; leaving the map anywhere else is a wall.
  assign w_curBlocked = !w_curNbr.tunnel && (w_curNbr.outside || q_cur_wall);
  assign w_reqBlocked = !w_reqNbr.tunnel && (w_reqNbr.outside || q_req_wall);

  // Turn decision then movement, both in one pass. A reversal is taken
  // anywhere; any other request waits for alignment and an open tile. The
  // step after a turn uses the new direction and the wall bit that goes with
  // it, so a turn and its first pixel land on the same edge.
  always_comb begin
    w_turn        = 1'b0;
    w_nextDir     = r_dir;
    w_nextState   = r_state;
    w_nextX       = r_x;
    w_nextY       = r_y;
    if (w_reqValid && (w_reqDir == opposite(r_dir))) begin
      w_turn = 1'b1;
    end else if (w_reqValid && w_aligned && !w_reqBlocked) begin
      w_turn = 1'b1;
    end
    if (w_turn) begin
      w_nextDir = w_reqDir;
    end
    w_moveDir     = w_turn ? w_reqDir : r_dir;
    w_moveBlocked = w_turn ? w_reqBlocked : w_curBlocked;
    if (w_aligned && w_moveBlocked) begin
      w_nextState = STOPPED;
    end else if ((r_state == MOVING) || w_turn) begin
      w_nextState = MOVING;
      case (w_moveDir)
        RIGHT:   w_nextX = (r_x == WRAP_X) ? 9'd0 : r_x + 9'd1;
        LEFT:    w_nextX = (r_x == 9'd0) ? WRAP_X : r_x - 9'd1;
        UP:      w_nextY = r_y - 9'd1;
        default: w_nextY = r_y + 9'd1;
      endcase
    end
  end

  assign w_consume = w_turn;

  // Position, facing and FSM state all update together once per frame.
  always_ff @(posedge CLK60HZ) begin
    if (rst) begin
      r_x     <= 9'(START_X);
      r_y     <= 9'(START_Y);
      r_dir   <= LEFT;
      r_state <= STOPPED;
    end else begin
      r_x     <= w_nextX;
      r_y     <= w_nextY;
      r_dir   <= w_nextDir;
      r_state <= w_nextState;
    end
  end

  assign x_pac  = r_x;
  assign y_pac  = r_y;
  assign dir    = r_dir;
  assign moving = (r_state == MOVING);

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pacman_motion_ctrl
// Drives directed and random button sequences over several maze maps and
// compares every frame against a pixel-level reference model of Pacman's
// movement rules.
// ---------------------------------------------------------------------------
module tb_pacman_motion_ctrl;

  logic       CLK60HZ;
  logic       rst;
  logic       BTNU, BTND, BTNL, BTNR;
  logic [4:0] q_cur_tx, q_req_tx;
  logic [5:0] q_cur_ty, q_req_ty;
  logic       q_cur_wall, q_req_wall;
  logic [8:0] x_pac, y_pac;
  logic [1:0] dir;
  logic       moving;

  int checks = 0;
  int errors = 0;

  bit mapWall [36][28];

  // Reference model state (directions: 0=R 1=L 2=U 3=D)
  int mX, mY, mDir, mMoving, mReqValid, mReqDir;

  pacman_motion_ctrl dut (
    .CLK60HZ    (CLK60HZ),
    .rst        (rst),
    .BTNU       (BTNU),
    .BTND       (BTND),
    .BTNL       (BTNL),
    .BTNR       (BTNR),
    .q_cur_tx   (q_cur_tx),
    .q_cur_ty   (q_cur_ty),
    .q_cur_wall (q_cur_wall),
    .q_req_tx   (q_req_tx),
    .q_req_ty   (q_req_ty),
    .q_req_wall (q_req_wall),
    .x_pac      (x_pac),
    .y_pac      (y_pac),
    .dir        (dir),
    .moving     (moving)
  );

  initial CLK60HZ = 1'b0;
  always #5 CLK60HZ = ~CLK60HZ;

  // Map ROM: answers 0 off-map so the DUT must treat edges as walls itself.
  always_comb begin
    q_cur_wall = 1'b0;
    q_req_wall = 1'b0;
    if (int'(q_cur_ty) < 36 && int'(q_cur_tx) < 28) q_cur_wall = mapWall[q_cur_ty][q_cur_tx];
    if (int'(q_req_ty) < 36 && int'(q_req_tx) < 28) q_req_wall = mapWall[q_req_ty][q_req_tx];
  end

  function automatic int dxOf(input int d);
    return (d == 0) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  function automatic int dyOf(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int oppositeOf(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
  endfunction

  // Tile ahead of pixel (x,y) in direction d: expected query coords, whether
  // those coords are meaningful, and whether the tile blocks movement.
  function automatic void probe(input int x, input int y, input int d,
                                output int ntx, output int nty,
                                output bit known, output bit blocked);
    ntx = x / 8 + dxOf(d);
    nty = y / 8 + dyOf(d);
    known = 1'b1;
    blocked = 1'b0;
    if (nty < 0 || nty >= 36) begin
      known = 1'b0;
      blocked = 1'b1;
    end else if (ntx < 0 || ntx >= 28) begin
      if (nty == 17) begin
        ntx = (ntx < 0) ? 27 : 0;
      end else begin
        known = 1'b0;
        blocked = 1'b1;
      end
    end else begin
      blocked = mapWall[nty][ntx];
    end
  endfunction

  function automatic void modelStep(input logic [3:0] btns, input logic doRst);
    int tx, ty, nx;
    bit known, blk, aligned, turned;
    if (doRst) begin
      mX = 80; mY = 64; mDir = 1; mMoving = 0; mReqValid = 0; mReqDir = 1;
      return;
    end
    aligned = (mX % 8 == 0) && (mY % 8 == 0);
    turned = 1'b0;
    if (mReqValid != 0) begin
      probe(mX, mY, mReqDir, tx, ty, known, blk);
      if (mReqDir == oppositeOf(mDir) || (aligned && !blk)) begin
        mDir = mReqDir;
        turned = 1'b1;
      end
    end
    probe(mX, mY, mDir, tx, ty, known, blk);
    if (aligned && blk) begin
      mMoving = 0;
    end else if (mMoving != 0 || turned) begin
      mMoving = 1;
      nx = mX + dxOf(mDir);
      if (nx < 0) nx = 216;
      else if (nx > 216) nx = 0;
      mX = nx;
      mY = mY + dyOf(mDir);
    end
    if (turned) mReqValid = 0;
    if (btns != 4'b0000) begin
      mReqValid = 1;
      mReqDir = btns[3] ? 2 : btns[2] ? 3 : btns[1] ? 1 : 0;
    end
  endfunction

  task automatic checkOutput();
    int tx, ty, eff;
    bit known, blk;
    logic [8:0] expX, expY;
    logic [1:0] expDir;
    logic [4:0] expTx;
    logic [5:0] expTy;
    expX = mX[8:0];
    expY = mY[8:0];
    expDir = mDir[1:0];
    checks++;
    assert (x_pac === expX) else begin
      errors++; $error("FAIL x_pac got %0d want %0d", x_pac, expX);
    end
    checks++;
    assert (y_pac === expY) else begin
      errors++; $error("FAIL y_pac got %0d want %0d", y_pac, expY);
    end
    checks++;
    assert (dir === expDir) else begin
      errors++; $error("FAIL dir got %0d want %0d", dir, expDir);
    end
    checks++;
    assert (moving === (mMoving != 0)) else begin
      errors++; $error("FAIL moving got %0b want %0d", moving, mMoving);
    end
    probe(mX, mY, mDir, tx, ty, known, blk);
    if (known) begin
      expTx = tx[4:0];
      expTy = ty[5:0];
      checks++;
      assert ({q_cur_ty, q_cur_tx} === {expTy, expTx}) else begin
        errors++; $error("FAIL q_cur got (%0d,%0d) want (%0d,%0d)", q_cur_tx, q_cur_ty, expTx, expTy);
      end
    end
    eff = (mReqValid != 0) ? mReqDir : mDir;
    probe(mX, mY, eff, tx, ty, known, blk);
    if (known) begin
      expTx = tx[4:0];
      expTy = ty[5:0];
      checks++;
      assert ({q_req_ty, q_req_tx} === {expTy, expTx}) else begin
        errors++; $error("FAIL q_req got (%0d,%0d) want (%0d,%0d)", q_req_tx, q_req_ty, expTx, expTy);
      end
    end
  endtask

  // One frame: drive inputs, advance the model, let the edge happen, check.
  task automatic applyStimulus(input logic [3:0] btns, input logic doRst);
    BTNU = btns[3];
    BTND = btns[2];
    BTNL = btns[1];
    BTNR = btns[0];
    rst  = doRst;
    modelStep(btns, doRst);
    @(posedge CLK60HZ);
    @(negedge CLK60HZ);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0);
  endtask

  // Advance until the model reaches a coordinate; running out of frames is
  // itself a failure.
  task automatic waitFor(input bit useY, input int target, input int budget);
    int left;
    left = budget;
    while (((useY ? mY : mX) != target) && left > 0) begin
      applyStimulus(4'b0000, 1'b0);
      left--;
    end
    checks++;
    assert (left > 0 || (useY ? mY : mX) == target) else begin
      errors++; $error("FAIL waitFor got %0d want %0d", useY ? mY : mX, target);
    end
  endtask

  task automatic clearMap();
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        mapWall[r][c] = 1'b0;
  endtask

  initial begin
    BTNU = 0; BTND = 0; BTNL = 0; BTNR = 0; rst = 1;
    clearMap();
    @(negedge CLK60HZ);

    // Reset state
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Single LEFT pulse on an open map, then reverse, then U+R together
    applyStimulus(4'b0010, 1'b0);
    idle(6);
    applyStimulus(4'b0001, 1'b0);
    idle(4);
    applyStimulus(4'b1001, 1'b0);
    idle(12);

    // Reset while moving drops position and any request
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    idle(4);

    // Reverse into a wall from standstill: faces right but stays put
    mapWall[8][11] = 1'b1;
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    idle(4);
    mapWall[8][11] = 1'b0;

    // Tunnel row wrap in both directions
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    waitFor(1'b1, 130, 200);
    applyStimulus(4'b0010, 1'b0);
    waitFor(1'b0, 0, 200);
    idle(4);
    applyStimulus(4'b0001, 1'b0);
    idle(12);

    // Row 16: the left edge is a wall, Pacman stops at x=0
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    waitFor(1'b1, 122, 200);
    applyStimulus(4'b0010, 1'b0);
    waitFor(1'b0, 0, 200);
    idle(10);

    // Random mazes with random button activity and occasional resets
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < 36; r++)
        for (int c = 0; c < 28; c++)
          mapWall[r][c] = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 28; c++) mapWall[17][c] = 1'b0;
      mapWall[8][10] = 1'b0;
      applyStimulus(4'b0000, 1'b1);
      for (int i = 0; i < 700; i++) begin
        logic [3:0] b;
        b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        applyStimulus(b, ($urandom_range(0, 299) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
